rps_match_scorer: RTL and testbench

- Sequential scorekeeper directly downstream of the combinational rock-paper-scissors round judge.
- Samples the judge's one-hot result (player_a_wins / player_b_wins / tie_game) when a round is qualified by round_valid.
- Accumulates per-player scores, a tie count and a round count, and declares the match winner when either player reaches WIN_TARGET.
- Drives the scoreboard/display logic.

---
 rtl/rps_match_scorer.sv | 166 ++++++++++++++++
 tb/tb_rps_match_scorer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/rps_match_scorer.sv
//==============================================================================
// Module   : rps_match_scorer
// Purpose  : Match scorekeeper fed by the rock-paper-scissors round judge.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module rps_match_scorer #(
    parameter int WIN_TARGET = 3,
    parameter int SCORE_W    = 3,
    parameter int ROUND_W    = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               round_valid,
    input  logic               player_a_wins,
    input  logic               player_b_wins,
    input  logic               tie_game,
    output logic [SCORE_W-1:0] score_a,
    output logic [SCORE_W-1:0] score_b,
    output logic [SCORE_W-1:0] tie_count,
    output logic [ROUND_W-1:0] round_count,
    output logic               busy,
    output logic               match_over,
    output logic               winner_a,
    output logic               winner_b,
    output logic               illegal_result
);

    generate
        if (WIN_TARGET < 1 || WIN_TARGET > (2**SCORE_W - 1)) begin : g_param_check
            $error("rps_match_scorer: WIN_TARGET out of range for SCORE_W");
        end
    endgenerate

    localparam logic [SCORE_W-1:0] c_WIN   = SCORE_W'(WIN_TARGET);
    localparam logic [SCORE_W-1:0] c_S_MAX = {SCORE_W{1'b1}};
    localparam logic [ROUND_W-1:0] c_R_MAX = {ROUND_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_OVER = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [SCORE_W-1:0] score_a_q, score_a_d;
    logic [SCORE_W-1:0] score_b_q, score_b_d;
    logic [SCORE_W-1:0] tie_q, tie_d;
    logic [ROUND_W-1:0] round_q, round_d;
    logic               win_a_q, win_a_d;
    logic               win_b_q, win_b_d;
    logic               illegal_q, illegal_d;

    logic               w_one_hot;
    logic [SCORE_W-1:0] w_a_inc;
    logic [SCORE_W-1:0] w_b_inc;

    // Exactly one of three flags: odd parity and not all three set.
    assign w_one_hot = (player_a_wins ^ player_b_wins ^ tie_game) &
                       ~(player_a_wins & player_b_wins & tie_game);
    assign w_a_inc   = score_a_q + SCORE_W'(1);
    assign w_b_inc   = score_b_q + SCORE_W'(1);

    always_comb begin
        state_d   = state_q;
        score_a_d = score_a_q;
        score_b_d = score_b_q;
        tie_d     = tie_q;
        round_d   = round_q;
        win_a_d   = win_a_q;
        win_b_d   = win_b_q;
        illegal_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    score_a_d = '0;
                    score_b_d = '0;
                    tie_d     = '0;
                    round_d   = '0;
                    state_d   = S_PLAY;
                end
            end
            S_PLAY: begin
                if (start) begin
                    score_a_d = '0;
                    score_b_d = '0;
                    tie_d     = '0;
                    round_d   = '0;
                end else if (round_valid) begin
                    if (w_one_hot) begin
                        if (round_q != c_R_MAX) round_d = round_q + ROUND_W'(1);
                        if (player_a_wins) begin
                            score_a_d = w_a_inc;
                            if (w_a_inc == c_WIN) begin
                                win_a_d = 1'b1;
                                state_d = S_OVER;
                            end
                        end else if (player_b_wins) begin
                            score_b_d = w_b_inc;
                            if (w_b_inc == c_WIN) begin
                                win_b_d = 1'b1;
                                state_d = S_OVER;
                            end
                        end else if (tie_q != c_S_MAX) begin
                            tie_d = tie_q + SCORE_W'(1);
                        end
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
            end
            S_OVER: begin
                if (start) begin
                    score_a_d = '0;
                    score_b_d = '0;
                    tie_d     = '0;
                    round_d   = '0;
                    win_a_d   = 1'b0;
                    win_b_d   = 1'b0;
                    state_d   = S_PLAY;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            score_a_q <= '0;
            score_b_q <= '0;
            tie_q     <= '0;
            round_q   <= '0;
            win_a_q   <= 1'b0;
            win_b_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            score_a_q <= score_a_d;
            score_b_q <= score_b_d;
            tie_q     <= tie_d;
            round_q   <= round_d;
            win_a_q   <= win_a_d;
            win_b_q   <= win_b_d;
            illegal_q <= illegal_d;
        end
    end

    assign score_a        = score_a_q;
    assign score_b        = score_b_q;
    assign tie_count      = tie_q;
    assign round_count    = round_q;
    assign busy           = (state_q == S_PLAY);
    assign match_over     = (state_q == S_OVER);
    assign winner_a       = win_a_q;
    assign winner_b       = win_b_q;
    assign illegal_result = illegal_q;

endmodule

`default_nettype wire

// File: tb/tb_rps_match_scorer.sv
//==============================================================================
// Module   : tb_rps_match_scorer
// Purpose  : Directed bench for rps_match_scorer (targets 3 and 7) against a rule model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_rps_match_scorer;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic round_valid = 1'b0;
    logic pa = 1'b0;
    logic pb = 1'b0;
    logic pt = 1'b0;

    logic [2:0] sa [2];
    logic [2:0] sb [2];
    logic [2:0] tc [2];
    logic [7:0] rc [2];
    logic       bsy [2];
    logic       ovr [2];
    logic       wa [2];
    logic       wb [2];
    logic       ill [2];

    always #5 clk = ~clk;

    rps_match_scorer #(.WIN_TARGET(3), .SCORE_W(3), .ROUND_W(8)) u_dut3 (
        .clk(clk), .reset(reset), .start(start), .round_valid(round_valid),
        .player_a_wins(pa), .player_b_wins(pb), .tie_game(pt),
        .score_a(sa[0]), .score_b(sb[0]), .tie_count(tc[0]), .round_count(rc[0]),
        .busy(bsy[0]), .match_over(ovr[0]), .winner_a(wa[0]), .winner_b(wb[0]),
        .illegal_result(ill[0])
    );

    rps_match_scorer #(.WIN_TARGET(7), .SCORE_W(3), .ROUND_W(8)) u_dut7 (
        .clk(clk), .reset(reset), .start(start), .round_valid(round_valid),
        .player_a_wins(pa), .player_b_wins(pb), .tie_game(pt),
        .score_a(sa[1]), .score_b(sb[1]), .tie_count(tc[1]), .round_count(rc[1]),
        .busy(bsy[1]), .match_over(ovr[1]), .winner_a(wa[1]), .winner_b(wb[1]),
        .illegal_result(ill[1])
    );

    // Rule model: phase 0=idle, 1=playing, 2=match decided.
    int tgt [2] = '{3, 7};
    int m_sa [2], m_sb [2], m_tc [2], m_rc [2], m_ph [2], m_wa [2], m_wb [2], m_ill [2];
    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input int k, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s[tgt=%0d] @%0t: got %0d expected %0d", name, tgt[k], $time, act, exp);
        end
    endtask

    task automatic model_step(input bit st, input bit rv, input bit a, input bit b,
                              input bit t, input bit rs);
        for (int k = 0; k < 2; k++) begin
            m_ill[k] = 0;
            if (rs) begin
                m_sa[k] = 0; m_sb[k] = 0; m_tc[k] = 0; m_rc[k] = 0;
                m_ph[k] = 0; m_wa[k] = 0; m_wb[k] = 0;
            end else if (st && m_ph[k] != 0 || st && m_ph[k] == 0) begin
                m_sa[k] = 0; m_sb[k] = 0; m_tc[k] = 0; m_rc[k] = 0;
                m_wa[k] = 0; m_wb[k] = 0; m_ph[k] = 1;
            end else if (m_ph[k] == 1 && rv) begin
                if (int'(a) + int'(b) + int'(t) == 1) begin
                    m_rc[k] = (m_rc[k] + 1 > 255) ? 255 : m_rc[k] + 1;
                    if (a) m_sa[k]++;
                    if (b) m_sb[k]++;
                    if (t) m_tc[k] = (m_tc[k] + 1 > 7) ? 7 : m_tc[k] + 1;
                    if (m_sa[k] == tgt[k]) begin m_wa[k] = 1; m_ph[k] = 2; end
                    if (m_sb[k] == tgt[k]) begin m_wb[k] = 1; m_ph[k] = 2; end
                end else begin
                    m_ill[k] = 1;
                end
            end
        end
    endtask

    task automatic cyc(input bit st, input bit rv, input bit a, input bit b,
                       input bit t, input bit rs);
        start = st; round_valid = rv; pa = a; pb = b; pt = t; reset = rs;
        @(posedge clk);
        model_step(st, rv, a, b, t, rs);
        #1;
        start = 1'b0; round_valid = 1'b0; pa = 1'b0; pb = 1'b0; pt = 1'b0; reset = 1'b0;
    endtask

    task automatic idle();           cyc(0, 0, 0, 0, 0, 0); endtask
    task automatic go();             cyc(1, 0, 0, 0, 0, 0); endtask
    task automatic rnd(input bit a, input bit b, input bit t); cyc(0, 1, a, b, t, 0); endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                chk("score_a", k, int'(sa[k]), m_sa[k]);
                chk("score_b", k, int'(sb[k]), m_sb[k]);
                chk("tie_count", k, int'(tc[k]), m_tc[k]);
                chk("round_count", k, int'(rc[k]), m_rc[k]);
                chk("busy", k, int'(bsy[k]), int'(m_ph[k] == 1));
                chk("match_over", k, int'(ovr[k]), int'(m_ph[k] == 2));
                chk("winner_a", k, int'(wa[k]), m_wa[k]);
                chk("winner_b", k, int'(wb[k]), m_wb[k]);
                chk("illegal", k, int'(ill[k]), m_ill[k]);
            end
        end
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_sa[k] = 0; m_sb[k] = 0; m_tc[k] = 0; m_rc[k] = 0;
            m_ph[k] = 0; m_wa[k] = 0; m_wb[k] = 0; m_ill[k] = 0;
        end
        cyc(0, 0, 0, 0, 0, 1);
        chk_en = 1'b1;
        cyc(0, 0, 0, 0, 0, 1);
        @(negedge clk); #1;
        chk("lit_reset_busy", 0, int'(bsy[0]), 0);
        chk("lit_reset_round", 0, int'(rc[0]), 0);

        // round_valid in idle must be ignored
        rnd(1, 0, 0);
        go();
        rnd(1, 0, 0); rnd(1, 0, 0); rnd(1, 0, 0);
        @(negedge clk); #1;
        chk("lit_t1_score_a", 0, int'(sa[0]), 3);
        chk("lit_t1_over", 0, int'(ovr[0]), 1);
        chk("lit_t1_winner_a", 0, int'(wa[0]), 1);
        chk("lit_t1_busy", 0, int'(bsy[0]), 0);
        chk("lit_t1_round", 0, int'(rc[0]), 3);

        go();
        rnd(0, 1, 0); rnd(0, 0, 1); rnd(1, 0, 0); rnd(0, 1, 0); rnd(0, 0, 1); rnd(0, 1, 0);
        @(negedge clk); #1;
        chk("lit_t2_score_a", 0, int'(sa[0]), 1);
        chk("lit_t2_score_b", 0, int'(sb[0]), 3);
        chk("lit_t2_ties", 0, int'(tc[0]), 2);
        chk("lit_t2_round", 0, int'(rc[0]), 6);
        chk("lit_t2_winner_b", 0, int'(wb[0]), 1);

        go();
        rnd(1, 0, 0);
        rnd(0, 0, 0);
        @(negedge clk); #1;
        chk("lit_t3_illegal_pulse", 0, int'(ill[0]), 1);
        idle();
        @(negedge clk); #1;
        chk("lit_t3_illegal_clear", 0, int'(ill[0]), 0);
        rnd(1, 1, 0);
        rnd(1, 1, 1);
        idle();
        @(negedge clk); #1;
        chk("lit_t3_round_held", 0, int'(rc[0]), 1);

        rnd(1, 0, 0); rnd(1, 0, 0);
        rnd(1, 0, 0);
        cyc(1, 1, 1, 0, 0, 0);
        @(negedge clk); #1;
        chk("lit_t4_restart_round", 0, int'(rc[0]), 0);
        chk("lit_t4_restart_busy", 0, int'(bsy[0]), 1);

        rnd(1, 0, 0); rnd(1, 0, 0); rnd(0, 1, 0);
        cyc(0, 1, 1, 0, 0, 1);
        rnd(1, 0, 0);
        @(negedge clk); #1;
        chk("lit_t5_reset_score_a", 0, int'(sa[0]), 0);
        chk("lit_t5_reset_over", 0, int'(ovr[0]), 0);

        go();
        for (int i = 0; i < 9; i++) rnd(0, 0, 1);
        for (int i = 0; i < 7; i++) rnd(1, 0, 0);
        idle();
        @(negedge clk); #1;
        chk("lit_t6_ties_sat", 1, int'(tc[1]), 7);
        chk("lit_t6_round", 1, int'(rc[1]), 16);
        chk("lit_t6_winner_a", 1, int'(wa[1]), 1);
        chk("lit_t6_t3_round", 0, int'(rc[0]), 12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
